// File: rtl/rbm_image_loader.sv
// rtl/rbm_image_loader.sv - pixel stream binariser/packer feeding the RBM classifier
// Optional build macro PIXEL_LFSR_EN: stochastic binarisation against a 16-bit LFSR
// instead of the fixed threshold.
module rbm_image_loader #(
  parameter int          general_input_dim = 784,
  parameter int          pixel_bitlength   = 8,
  parameter int          threshold         = 128,
  parameter int          count_bitlength   = 16,
  parameter logic [15:0] lfsr_seed         = 16'hACE1
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         pixel_valid,
  input  logic [pixel_bitlength-1:0]   pixel_data,
  output logic                         pixel_ready,
  output logic [general_input_dim-1:0] InputData,
  output logic                         data_valid,
  output logic                         rbm_reset,
  input  logic                         rbm_finish,
  output logic [count_bitlength-1:0]   image_count
);

  localparam int idx_w = (general_input_dim > 1) ? $clog2(general_input_dim) : 1;
  localparam logic [idx_w-1:0] last_idx = idx_w'(general_input_dim - 1);

  typedef enum logic [1:0] {LOAD, KICK, RUN, DONE} state_t;

  state_t                       state, state_nxt;
  logic [idx_w-1:0]             idx, idx_nxt;
  logic [general_input_dim-1:0] input_data_nxt;
  logic                         data_valid_nxt;
  logic                         rbm_reset_nxt;
  logic                         pixel_ready_nxt;
  logic [count_bitlength-1:0]   image_count_nxt;
  logic                         accept;
  logic                         pixel_bit;
  logic                         unused_cfg;

  // Handshake only counts while loading; pixel_ready is already low elsewhere.
  assign accept = (state == LOAD) && pixel_valid && pixel_ready;

`ifdef PIXEL_LFSR_EN
  logic [15:0] lfsr;

  // Fibonacci LFSR, taps 16,14,13,11; steps only on accepted pixels and survives across images.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      lfsr <= lfsr_seed;
    end else if (accept) begin
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
  end

  assign pixel_bit  = (pixel_data > lfsr[pixel_bitlength-1:0]);
  assign unused_cfg = ^threshold;
`else
  localparam logic [pixel_bitlength-1:0] thr = pixel_bitlength'(threshold);

  assign pixel_bit  = (pixel_data >= thr);
  assign unused_cfg = ^lfsr_seed;
`endif

  // State, pixel index and all registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= LOAD;
      idx         <= '0;
      InputData   <= '0;
      data_valid  <= 1'b0;
      pixel_ready <= 1'b0;
      rbm_reset   <= 1'b1;
      image_count <= '0;
    end else begin
      state       <= state_nxt;
      idx         <= idx_nxt;
      InputData   <= input_data_nxt;
      data_valid  <= data_valid_nxt;
      pixel_ready <= pixel_ready_nxt;
      rbm_reset   <= rbm_reset_nxt;
      image_count <= image_count_nxt;
    end
  end

  // Next state and next output values; outputs reflect the state being entered.
  always_comb begin
    state_nxt       = state;
    idx_nxt         = idx;
    input_data_nxt  = InputData;
    data_valid_nxt  = 1'b0;
    rbm_reset_nxt   = 1'b0;
    pixel_ready_nxt = 1'b0;
    image_count_nxt = image_count;
    case (state)
      LOAD: begin
        pixel_ready_nxt = 1'b1;
        if (accept) begin
          input_data_nxt[idx] = pixel_bit;
          if (idx == last_idx) begin
            // Ready drops on the accepting edge so no pixel of the next image slips in.
            idx_nxt         = '0;
            state_nxt       = KICK;
            rbm_reset_nxt   = 1'b1;
            pixel_ready_nxt = 1'b0;
          end else begin
            idx_nxt = idx + 1'b1;
          end
        end
      end
      KICK: begin
        state_nxt      = RUN;
        data_valid_nxt = 1'b1;
      end
      RUN: begin
        data_valid_nxt = 1'b1;
        if (rbm_finish) begin
          state_nxt       = DONE;
          data_valid_nxt  = 1'b0;
          image_count_nxt = image_count + 1'b1;
        end
      end
      DONE: begin
        state_nxt       = LOAD;
        pixel_ready_nxt = 1'b1;
      end
      default: state_nxt = LOAD;
    endcase
  end

endmodule
